uart_cmd_sequencer: RTL and testbench
=====================================

# uart_cmd_sequencer

Command-frame sequencer that sits directly behind the UART receive block. It consumes the received byte stream (byte strobe, byte, end-of-packet pulse), hunts for a sync byte, assembles an addressed, length-prefixed, checksummed frame into a local payload buffer, and then replays the payload as a sequence of register-bus writes over a valid/ready handshake. Malformed, truncated or overrunning frames are dropped and reported with an error code and a saturating error counter.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- MAX_LEN, 16, maximum payload bytes per frame (1..255)
- ERR_CNT_W, 8, width of saturating error counter

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data_ready  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- rx_endofpacket  in  1  one-cycle pulse, receiver line went idle
- wr_valid  out  1  write request valid
- wr_ready  in  1  write sink accepts
- wr_addr  out  8  write address
- wr_data  out  8  write data
- wr_last  out  1  marks final write of frame
- pkt_done  out  1  one-cycle pulse, frame fully written
- pkt_err  out  1  one-cycle pulse, error detected
- err_code  out  2  0=LEN, 1=CSUM, 2=TIMEOUT, 3=OVERRUN; valid with pkt_err, held until next error
- err_count  out  ERR_CNT_W  errors since reset, saturates at all-ones
- busy  out  1  state != IDLE

## Operation
- Frame: SYNC_BYTE, ADDR, LEN, LEN payload bytes, CSUM; CSUM = XOR of ADDR, LEN and all payload bytes.
- States: IDLE, ADDR, LEN, DATA, CSUM, PLAY.
- IDLE: byte == SYNC_BYTE -> ADDR; any other byte discarded silently; rx_endofpacket ignored.
- ADDR: capture base address, csum <= byte -> LEN.
- LEN: LEN == 0 or LEN > MAX_LEN -> pkt_err, err_code LEN, IDLE; otherwise capture, csum ^= byte, idx <= 0 -> DATA.
- DATA: buf[idx] <= byte, csum ^= byte, idx++; after byte LEN-1 stored -> CSUM.
- CSUM: byte == csum -> PLAY, k <= 0; mismatch -> pkt_err, err_code CSUM, IDLE.
- rx_endofpacket in ADDR/LEN/DATA/CSUM with no byte that cycle -> pkt_err, err_code TIMEOUT, IDLE. Byte and end-of-packet in the same cycle: byte processed, end-of-packet ignored.
- PLAY: wr_valid = 1, wr_addr = base + k (mod 256, wraps FF->00), wr_data = buf[k], wr_last = (k == LEN-1). On wr_valid & wr_ready: k++; on the last handshake -> IDLE, pkt_done.
- rx byte during PLAY: dropped, pkt_err with err_code OVERRUN; playout continues unaffected.
- err_count increments on every pkt_err, saturating.

## Timing
- Reset: all outputs 0, state IDLE, err_count 0, err_code 0. Reset during PLAY drops wr_valid the following cycle; no pkt_done issued; frame lost.
- Each byte is consumed in its strobe cycle; state and registers update at the next edge.
- CSUM byte strobe at cycle t -> wr_valid high at t+1.
- wr_addr/wr_data/wr_last stable while wr_valid & !wr_ready; wr_valid never deasserts without a handshake (except reset).
- wr_ready held high: one write per cycle, LEN cycles total.
- Final handshake at cycle h -> pkt_done high at h+1, busy low at h+1; a SYNC_BYTE strobed at h+1 is accepted.
- pkt_err asserts the cycle after the offending byte or end-of-packet pulse.

## Structure
- Package uart_cmd_pkg: state enum, err_code constants (ERR_LEN, ERR_CSUM, ERR_TIMEOUT, ERR_OVERRUN), default SYNC_BYTE.
- Sub-module cmd_payload_buf: MAX_LEN x 8, one synchronous write port, one asynchronous read port indexed by k.
- Top holds the FSM, checksum, idx/k counters, error logic.

## Test plan
- A5 10 02 01 02 11, wr_ready=1 -> writes (10,01), (11,02,last) on consecutive cycles; pkt_done once; err_count 0.
- A5 FF 02 3C C3 02 -> writes (FF,3C), (00,C3,last); address wraps.
- A5 10 02 01 02 12 -> pkt_err, err_code 1, no wr_valid, err_count 1; a following good frame is written normally.
- A5 20 00 and A5 20 11 (MAX_LEN=16) -> two pkt_err with err_code 0; err_count 2.
- A5 30 03 AA then rx_endofpacket -> pkt_err, err_code 2, IDLE; a stray 55 before the next A5 is ignored.
- Good 3-byte frame with wr_ready low for 3 cycles per write, plus one rx byte injected during PLAY -> outputs held stable while stalled, all 3 writes complete, one OVERRUN error, pkt_done after the last handshake.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame sequencer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StCsum,
    StPlay
  } state_e;

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/cmd_payload_buf.sv
// Frame payload store: one synchronous write port, one asynchronous read port.
module cmd_payload_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Hunts for sync, assembles an addressed checksummed frame, then replays the
// payload as register writes over a valid/ready handshake.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_data_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_endofpacket,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [7:0]           wr_addr,
  output logic [7:0]           wr_data,
  output logic                 wr_last,
  output logic                 pkt_done,
  output logic                 pkt_err,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  localparam int unsigned BufAw   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

  state_e     state_q;
  logic [7:0] base_q, len_q, csum_q, idx_q, k_q;
  logic       err_fire;
  logic [1:0] err_kind;
  logic       buf_we;
  logic [7:0] buf_rdata;
  logic       eop_only, len_bad, play, last_k;

  assign eop_only = rx_endofpacket && !rx_data_ready;
  assign len_bad  = (rx_data == 8'd0) || (rx_data > MaxLenB);
  assign play     = (state_q == StPlay);
  assign last_k   = (k_q == len_q - 8'd1);
  assign buf_we   = (state_q == StData) && rx_data_ready;

  cmd_payload_buf #(
    .Depth(MAX_LEN),
    .AddrW(BufAw)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(idx_q[BufAw-1:0]),
    .wdata(rx_data),
    .raddr(k_q[BufAw-1:0]),
    .rdata(buf_rdata)
  );

  always_comb begin
    err_fire = 1'b0;
    err_kind = ERR_LEN;
    unique case (state_q)
      StAddr, StData: begin
        if (eop_only) begin
          err_fire = 1'b1;
          err_kind = ERR_TIMEOUT;
        end
      end
      StLen: begin
        if (rx_data_ready && len_bad) begin
          err_fire = 1'b1;
          err_kind = ERR_LEN;
        end else if (eop_only) begin
          err_fire = 1'b1;
          err_kind = ERR_TIMEOUT;
        end
      end
      StCsum: begin
        if (rx_data_ready && (rx_data != csum_q)) begin
          err_fire = 1'b1;
          err_kind = ERR_CSUM;
        end else if (eop_only) begin
          err_fire = 1'b1;
          err_kind = ERR_TIMEOUT;
        end
      end
      // Bytes arriving during playout are dropped but reported.
      StPlay: begin
        if (rx_data_ready) begin
          err_fire = 1'b1;
          err_kind = ERR_OVERRUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      base_q    <= 8'd0;
      len_q     <= 8'd0;
      csum_q    <= 8'd0;
      idx_q     <= 8'd0;
      k_q       <= 8'd0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= ERR_LEN;
      err_count <= '0;
    end else begin
      pkt_done <= 1'b0;
      pkt_err  <= err_fire;
      if (err_fire) begin
        err_code <= err_kind;
        if (!(&err_count)) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
      end
      unique case (state_q)
        StIdle: begin
          if (rx_data_ready && (rx_data == SYNC_BYTE)) state_q <= StAddr;
        end
        StAddr: begin
          if (rx_data_ready) begin
            base_q  <= rx_data;
            csum_q  <= rx_data;
            state_q <= StLen;
          end else if (rx_endofpacket) begin
            state_q <= StIdle;
          end
        end
        StLen: begin
          if (rx_data_ready) begin
            if (len_bad) begin
              state_q <= StIdle;
            end else begin
              len_q   <= rx_data;
              csum_q  <= csum_q ^ rx_data;
              idx_q   <= 8'd0;
              state_q <= StData;
            end
          end else if (rx_endofpacket) begin
            state_q <= StIdle;
          end
        end
        StData: begin
          if (rx_data_ready) begin
            csum_q <= csum_q ^ rx_data;
            idx_q  <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_q <= StCsum;
          end else if (rx_endofpacket) begin
            state_q <= StIdle;
          end
        end
        StCsum: begin
          if (rx_data_ready) begin
            if (rx_data == csum_q) begin
              k_q     <= 8'd0;
              state_q <= StPlay;
            end else begin
              state_q <= StIdle;
            end
          end else if (rx_endofpacket) begin
            state_q <= StIdle;
          end
        end
        StPlay: begin
          if (wr_ready) begin
            k_q <= k_q + 8'd1;
            if (last_k) begin
              state_q  <= StIdle;
              pkt_done <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_valid = play;
  assign wr_addr  = play ? (base_q + k_q) : 8'd0;
  assign wr_data  = play ? buf_rdata : 8'd0;
  assign wr_last  = play && last_k;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Randomized frame-level bench for uart_cmd_sequencer with a frame-rule scoreboard.
module tb_uart_cmd_sequencer;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         MAXL = 16;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic       l;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_data_ready = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_endofpacket = 1'b0;
  logic       wr_valid, wr_ready, wr_last, pkt_done, pkt_err, busy;
  logic [7:0] wr_addr, wr_data, err_count;
  logic [1:0] err_code;

  uart_cmd_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .rx_data_ready (rx_data_ready),
    .rx_data       (rx_data),
    .rx_endofpacket(rx_endofpacket),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_last       (wr_last),
    .pkt_done      (pkt_done),
    .pkt_err       (pkt_err),
    .err_code      (err_code),
    .err_count     (err_count),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad = 0;
  wr_t        exp_wr[$];
  logic [1:0] exp_err[$];
  int         model_errs = 0;
  int         exp_done = 0;
  int         done_seen = 0;
  logic [7:0] pl[256];
  int         ready_mode = 0;
  int         stall_ctr = 0;
  bit         mon_en = 1'b0;
  bit         prev_stall = 1'b0;
  bit         last_hs_q = 1'b0;
  logic [17:0] prev_vec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0: always ready, 1: random, 2: three low cycles then one high, other: never ready
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: wr_ready = 1'b1;
      1: wr_ready = ($urandom_range(3) != 0);
      2: begin
        wr_ready  = (stall_ctr == 3);
        stall_ctr = (stall_ctr == 3) ? 0 : stall_ctr + 1;
      end
      default: wr_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    wr_t        e;
    logic [1:0] c;
    if (mon_en) begin
      if (prev_stall)
        check("stall_hold", 32'({wr_valid, wr_addr, wr_data, wr_last}), 32'(prev_vec));
      if (last_hs_q || pkt_done) begin
        check("pkt_done", 32'(pkt_done), 32'(last_hs_q));
        if (last_hs_q) check("busy_after_done", 32'(busy), 32'd0);
      end
      if (pkt_done) done_seen++;
      if (wr_valid && wr_ready) begin
        if (exp_wr.size() == 0) begin
          check("wr_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_wr.pop_front();
          check("wr_beat", 32'({wr_addr, wr_data, wr_last}), 32'(e));
        end
      end
      if (pkt_err) begin
        if (exp_err.size() == 0) begin
          check("err_unexpected", 32'd1, 32'd0);
        end else begin
          c = exp_err.pop_front();
          check("err_code", 32'(err_code), 32'(c));
        end
        check("err_count", 32'(err_count), 32'(model_errs));
      end
      last_hs_q  = wr_valid && wr_ready && wr_last;
      prev_stall = wr_valid && !wr_ready;
      prev_vec   = {1'b0, wr_valid, wr_addr, wr_data, wr_last};
    end else begin
      last_hs_q  = 1'b0;
      prev_stall = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic gap();
    idle($urandom_range(0, 2));
  endtask

  task automatic put_byte(input logic [7:0] b, input bit eop);
    rx_data        = b;
    rx_data_ready  = 1'b1;
    rx_endofpacket = eop;
    idle(1);
    rx_data_ready  = 1'b0;
    rx_endofpacket = 1'b0;
  endtask

  task automatic eop_pulse();
    rx_endofpacket = 1'b1;
    idle(1);
    rx_endofpacket = 1'b0;
  endtask

  task automatic push_err(input logic [1:0] code);
    exp_err.push_back(code);
    if (model_errs < 255) model_errs++;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 600 && done_seen < exp_done; i++) idle(1);
    check("done_wait", 32'(done_seen), 32'(exp_done));
  endtask

  // mode 0: good, 1: corrupted checksum, 2: eop after `cut` bytes following sync
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] lenb, input int mode,
                            input int cut, input bit ovr);
    logic [7:0] bytes[$];
    logic [7:0] cs;
    wr_t        w;
    bit         bad_len;
    bad_len = (lenb == 8'd0) || (int'(lenb) > MAXL);
    bytes.push_back(addr);
    bytes.push_back(lenb);
    cs = addr ^ lenb;
    if (!bad_len) begin
      for (int i = 0; i < int'(lenb); i++) begin
        bytes.push_back(pl[i]);
        cs ^= pl[i];
      end
    end
    put_byte(SYNC, $urandom_range(7) == 0);
    gap();
    if (bad_len) begin
      put_byte(addr, 1'b0);
      gap();
      push_err(2'd0);
      put_byte(lenb, 1'b0);
      idle(2);
      return;
    end
    if (mode == 2) begin
      for (int i = 0; i < cut; i++) begin
        put_byte(bytes[i], $urandom_range(7) == 0);
        gap();
      end
      push_err(2'd2);
      eop_pulse();
      idle(2);
      return;
    end
    foreach (bytes[i]) begin
      put_byte(bytes[i], $urandom_range(7) == 0);
      gap();
    end
    if (mode == 1) begin
      push_err(2'd1);
      put_byte(cs ^ 8'($urandom_range(1, 255)), 1'b0);
      idle(3);
      return;
    end
    for (int i = 0; i < int'(lenb); i++) begin
      w.a = addr + 8'(i);
      w.d = pl[i];
      w.l = (i == int'(lenb) - 1);
      exp_wr.push_back(w);
    end
    exp_done++;
    put_byte(cs, 1'b0);
    if (ovr) begin
      push_err(2'd3);
      put_byte(8'($urandom), 1'b0);
    end
  endtask

  task automatic junk();
    logic [7:0] b;
    repeat ($urandom_range(0, 3)) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h5A;
      put_byte(b, $urandom_range(3) == 0);
      if ($urandom_range(3) == 0) eop_pulse();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         len;
    int         mode;
    logic [7:0] lb;
    idle(3);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_outputs", 32'({wr_addr, wr_data, wr_last}), 32'd0);
    check("rst_flags", 32'({pkt_done, pkt_err, busy}), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    idle(1);
    mon_en = 1'b1;

    ready_mode = 0;
    pl[0] = 8'h01; pl[1] = 8'h02;
    send_frame(8'h10, 8'd2, 0, 0, 1'b0);
    wait_done();
    check("good_no_err", 32'(err_count), 32'd0);

    pl[0] = 8'h3C; pl[1] = 8'hC3;
    send_frame(8'hFF, 8'd2, 0, 0, 1'b0);
    wait_done();

    pl[0] = 8'h01; pl[1] = 8'h02;
    send_frame(8'h10, 8'd2, 1, 0, 1'b0);
    send_frame(8'h10, 8'd2, 0, 0, 1'b0);
    wait_done();

    send_frame(8'h20, 8'h00, 0, 0, 1'b0);
    send_frame(8'h20, 8'h11, 0, 0, 1'b0);

    pl[0] = 8'hAA;
    send_frame(8'h30, 8'd3, 2, 3, 1'b0);
    put_byte(8'h55, 1'b0);
    check("stray_ignored", 32'(busy), 32'd0);
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    send_frame(8'h40, 8'd3, 0, 0, 1'b0);
    wait_done();

    ready_mode = 2;
    pl[0] = 8'h9A; pl[1] = 8'hA5; pl[2] = 8'h00;
    send_frame(8'h7E, 8'd3, 0, 0, 1'b1);
    wait_done();

    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      junk();
      case ($urandom_range(9))
        0: len = 0;
        1: len = $urandom_range(MAXL + 1, 255);
        default: len = $urandom_range(1, MAXL);
      endcase
      lb = 8'(len);
      for (int i = 0; i < 256; i++) pl[i] = 8'($urandom);
      mode = ($urandom_range(3) == 0) ? $urandom_range(1, 2) : 0;
      send_frame(8'($urandom), lb, mode, (len > 0) ? $urandom_range(0, len + 2) : 0,
                 $urandom_range(2) == 0);
      if (mode == 0 && len >= 1 && len <= MAXL) wait_done();
    end
    idle(4);
    check("err_count_total", 32'(err_count), 32'(model_errs));

    // Reset while stalled in playout: frame must be lost without pkt_done.
    ready_mode = 3;
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    send_frame(8'h50, 8'd3, 0, 0, 1'b0);
    idle(2);
    check("play_before_reset", 32'(wr_valid), 32'd1);
    mon_en = 1'b0;
    reset  = 1'b1;
    idle(1);
    reset  = 1'b0;
    check("reset_drops_valid", 32'(wr_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_err_count", 32'(err_count), 32'd0);
    check("reset_done", 32'(pkt_done), 32'd0);
    exp_wr.delete();
    exp_err.delete();
    exp_done--;
    model_errs = 0;
    mon_en = 1'b1;
    ready_mode = 1;
    idle(5);
    send_frame(8'h60, 8'd3, 0, 0, 1'b0);
    wait_done();
    idle(4);

    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("err_queue_empty", 32'(exp_err.size()), 32'd0);
    check("err_count_final", 32'(err_count), 32'(model_errs));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
